// File: rtl/nn_pkg.sv
// Shared fixed-point constants, operand type and FSM state encoding for the
// serial output-layer neuron.
package nn_pkg;

  localparam int Q34_FRAC = 4;
  localparam int Q44_FRAC = 4;

  localparam logic signed [7:0] Q44_MAX = 8'sh7F;
  localparam logic signed [7:0] Q44_MIN = 8'sh80;

  typedef logic signed [7:0] q34_t;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/Sigmoid_unit.sv
// Piecewise-linear sigmoid: signed Q4.4 in, unsigned Q0.8 out (1.0 clamps to 0xFF).
// Segments break at |x| = 1.0, 2.375 and 5.0; negative inputs use 1 - f(|x|).
module Sigmoid_unit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH-1:0] x_i,
  output logic        [DATA_WIDTH-1:0] y_o
);

  int mag;
  int f;
  int r;

  always_comb begin
    mag = (x_i < 0) ? -int'(x_i) : int'(x_i);
    if (mag < 16) begin
      f = 4 * mag + 128;
    end else if (mag < 38) begin
      f = 2 * mag + 160;
    end else if (mag < 80) begin
      f = mag / 2 + 216;
    end else begin
      f = 256;
    end
    r = (x_i < 0) ? 256 - f : f;
    if (r > 255) begin
      r = 255;
    end
    y_o = DATA_WIDTH'(r);
  end

endmodule

// File: rtl/mac_q34.sv
// Signed multiply-accumulate: full-precision product, sign-extended into a
// wide accumulator. Synchronous clear wins over enable.
module mac_q34 #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_W      = 19
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [ACC_W-1:0]      acc_o
);

  localparam int MUL_W = 2 * DATA_WIDTH;

  logic signed [MUL_W-1:0] a_ext;
  logic signed [MUL_W-1:0] b_ext;
  logic signed [MUL_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  assign a_ext    = {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i};
  assign b_ext    = {{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W-MUL_W){prod[MUL_W-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/sat_rounding_Q44.sv
// Round-half-up and saturate a wide signed fixed-point value to Q4.4.
// The input carries DATA_WIDTH-INT_LENGTH+1 fractional bits.
module sat_rounding_Q44
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = 19,
  parameter int INT_LENGTH = 12
) (
  input  logic signed [DATA_WIDTH-1:0] data_i,
  output logic signed [7:0]            data_o
);

  localparam int FRAC_IN  = DATA_WIDTH - INT_LENGTH + 1;
  localparam int SHIFT    = FRAC_IN - Q44_FRAC;
  localparam int HALF_INT = 1 << (SHIFT - 1);

  localparam logic signed [DATA_WIDTH:0] HALF = (DATA_WIDTH+1)'(HALF_INT);
  localparam logic signed [DATA_WIDTH:0] MAXV = (DATA_WIDTH+1)'(Q44_MAX);
  localparam logic signed [DATA_WIDTH:0] MINV = (DATA_WIDTH+1)'(Q44_MIN);

  logic signed [DATA_WIDTH:0] biased;
  logic signed [DATA_WIDTH:0] shifted;

  // One guard bit on top so the rounding add can never wrap.
  assign biased  = {data_i[DATA_WIDTH-1], data_i} + HALF;
  assign shifted = biased >>> SHIFT;

  always_comb begin
    data_o = shifted[7:0];
    if (shifted > MAXV) begin
      data_o = Q44_MAX;
    end else if (shifted < MINV) begin
      data_o = Q44_MIN;
    end
  end

endmodule

// File: rtl/stage2_serial_neuron.sv
// Output-layer neuron: serially MACs LENGTH Q3.4 beats, then rounds/saturates
// to Q4.4 and applies the sigmoid, holding the result until it is taken.
//
//   state | meaning
//   ACC   | accepting beats, accumulating products
//   CALC  | one cycle: register rounded sum and sigmoid
//   OUT   | result held on out_valid until out_ready
module stage2_serial_neuron
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic signed [DATA_WIDTH-1:0] in_wgt,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [DATA_WIDTH-1:0] out_data,
  output logic        [DATA_WIDTH-1:0] pre_act
);

  localparam int MUL_W = 2 * DATA_WIDTH;
  localparam int ACC_W = MUL_W + $clog2(LENGTH);
  localparam int CNT_W = $clog2(LENGTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0]   pre_act_q, pre_act_d;

  logic                    accept;
  logic                    mac_en;
  logic                    mac_clr;
  logic signed [ACC_W-1:0] acc;
  logic signed [7:0]       sat_val;
  logic [DATA_WIDTH-1:0]   sig_val;

  assign in_ready = (state_q == ACC);
  assign accept   = in_valid && in_ready;
  // A flush drops any beat offered in the same cycle.
  assign mac_en   = accept && !clr;
  assign mac_clr  = clr || ((state_q == OUT) && out_ready);

  mac_q34 #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_W     (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst_n(reset),
    .clr_i(mac_clr),
    .en_i (mac_en),
    .a_i  (in_data),
    .b_i  (in_wgt),
    .acc_o(acc)
  );

  sat_rounding_Q44 #(
    .DATA_WIDTH(ACC_W),
    .INT_LENGTH(ACC_W - 7)
  ) u_sat (
    .data_i(acc),
    .data_o(sat_val)
  );

  Sigmoid_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sig (
    .x_i(DATA_WIDTH'(sat_val)),
    .y_o(sig_val)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pre_act_d   = pre_act_q;
    if (clr) begin
      state_d     = ACC;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept) begin
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = CALC;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        CALC: begin
          pre_act_d   = DATA_WIDTH'(sat_val);
          out_data_d  = sig_val;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACC;
          end
        end
        default: begin
          state_d     = ACC;
          cnt_d       = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ACC;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pre_act_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pre_act_q   <= pre_act_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign pre_act   = pre_act_q;

endmodule

// File: tb/tb_stage2_serial_neuron.sv
// Directed plus randomized checks of stage2_serial_neuron against a real-valued
// model of the dot product, Q4.4 rounding and piecewise-linear sigmoid.
module tb_stage2_serial_neuron;

  localparam int DW  = 8;
  localparam int LEN = 8;

  logic          clk;
  logic          reset;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] in_wgt;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [DW-1:0] pre_act;

  int n_checks = 0;
  int n_fail   = 0;
  int vd [LEN];
  int vw [LEN];

  stage2_serial_neuron #(.DATA_WIDTH(DW), .LENGTH(LEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_wgt   (in_wgt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .pre_act  (pre_act)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact dot product in 2^-8 units, rounded half-up to Q4.4, saturated.
  function automatic int model_preact();
    int  s;
    real q;
    int  p;
    s = 0;
    for (int i = 0; i < LEN; i++) s += vd[i] * vw[i];
    q = $floor(real'(s) / 16.0 + 0.5);
    p = int'(q);
    if (p > 127)  p = 127;
    if (p < -128) p = -128;
    return p;
  endfunction

  // Reference sigmoid: PLAN-style segments on the real value, scaled to Q0.8.
  function automatic int model_sig(input int p);
    real a;
    real y;
    int  f;
    a = (p < 0) ? -p / 16.0 : p / 16.0;
    if (a < 1.0)        y = 0.25 * a + 0.5;
    else if (a < 2.375) y = 0.125 * a + 0.625;
    else if (a < 5.0)   y = 0.03125 * a + 0.84375;
    else                y = 1.0;
    f = int'($floor(y * 256.0));
    if (p < 0) f = 256 - f;
    if (f > 255) f = 255;
    return f;
  endfunction

  task automatic fill(input int d, input int w);
    for (int i = 0; i < LEN; i++) begin
      vd[i] = d;
      vw[i] = w;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beats(input int n);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    in_valid = 1'b1;
    while (got < n && cyc < 50) begin
      in_data = DW'(vd[got]);
      in_wgt  = DW'(vw[got]);
      if (in_ready) got++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("drive_beats", got, n);
  endtask

  // gap: 0 none, 1 alternate, 2 random. hold: cycles of out_ready=0 after out_valid.
  task automatic run_vector(input int gap, input int hold, input string name);
    int got;
    int cyc;
    int ep;
    int es;
    ep = model_preact() & 255;
    es = model_sig(model_preact());
    got = 0;
    cyc = 0;
    out_ready = (hold == 0);
    while (got < LEN && cyc < 200) begin
      if (gap == 0)      in_valid = 1'b1;
      else if (gap == 1) in_valid = (cyc % 2 == 0);
      else               in_valid = ($urandom_range(0, 1) == 1);
      in_data = DW'(vd[got]);
      in_wgt  = DW'(vw[got]);
      if (in_valid && in_ready) got++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk({name, "_beats"}, got, LEN);
    chk({name, "_calc_valid"}, out_valid, 1'b0);
    chk({name, "_calc_ready"}, in_ready, 1'b0);
    tick();
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_pre_act"}, pre_act, ep);
    chk({name, "_out_data"}, out_data, es);
    if (hold > 0) begin
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        in_data = DW'($urandom_range(0, 255));
        in_wgt  = DW'($urandom_range(0, 255));
        tick();
        chk({name, "_hold_valid"}, out_valid, 1'b1);
        chk({name, "_hold_pre"}, pre_act, ep);
        chk({name, "_hold_out"}, out_data, es);
        chk({name, "_hold_ready"}, in_ready, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    chk({name, "_done_valid"}, out_valid, 1'b0);
    chk({name, "_done_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    reset     = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_wgt    = '0;
    out_ready = 1'b1;
    #2 reset  = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_pre_act", pre_act, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk) reset = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1'b1);

    fill(16, 16);
    run_vector(0, 0, "sat_pos");
    chk("sat_pos_value", pre_act, 8'h7F);

    fill(8, 8);
    run_vector(0, 0, "nominal");
    chk("nominal_value", pre_act, 8'h20);

    fill(16, -16);
    run_vector(0, 0, "sat_neg");
    chk("sat_neg_value", pre_act, 8'h80);

    fill(0, 0);
    vd[3] = 1;
    vw[3] = 8;
    run_vector(0, 0, "round");
    chk("round_value", pre_act, 8'h01);

    fill(8, 8);
    run_vector(0, 5, "backpress");

    fill(8, 8);
    run_vector(1, 0, "gaps");
    chk("gaps_value", pre_act, 8'h20);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < LEN; i++) begin
        vd[i] = int'($urandom_range(0, 255)) - 128;
        vw[i] = int'($urandom_range(0, 255)) - 128;
        if (v < 4) begin
          vd[i] = vd[i] / 4;
          vw[i] = vw[i] / 4;
        end
      end
      run_vector(2, int'($urandom_range(0, 3)), "random");
    end

    // Reset part-way through a vector.
    fill(8, 8);
    drive_beats(4);
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_pre_act", pre_act, 0);
    chk("midrst_out_data", out_data, 0);
    @(negedge clk) reset = 1'b1;
    tick();
    run_vector(0, 0, "after_rst");
    chk("after_rst_value", pre_act, 8'h20);

    // Flush while a result is pending: it must be lost.
    fill(8, 8);
    out_ready = 1'b0;
    drive_beats(LEN);
    tick();
    chk("clr_pending_valid", out_valid, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_out_valid", out_valid, 1'b0);
    chk("clr_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (2) begin
      tick();
      chk("clr_lost", out_valid, 1'b0);
    end
    fill(16, -16);
    run_vector(0, 0, "after_clr");

    // Flush mid-vector with a beat offered in the same cycle.
    fill(8, 8);
    drive_beats(3);
    in_valid = 1'b1;
    in_data  = 8'h40;
    in_wgt   = 8'h40;
    clr      = 1'b1;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_mid_ready", in_ready, 1'b1);
    run_vector(0, 0, "after_clr_mid");
    chk("after_clr_mid_value", pre_act, 8'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
